// File: rtl/gcode_pkg.sv
// Shared definitions for the G-code motion sequencer: command codes, FSM
// state encodings and modal_state bit positions.
package gcode_pkg;

  typedef enum logic [3:0] {
    CMD_G00 = 4'd0,
    CMD_G01 = 4'd1,
    CMD_G20 = 4'd2,
    CMD_G21 = 4'd3,
    CMD_G90 = 4'd4,
    CMD_G91 = 4'd5,
    CMD_M2  = 4'd6,
    CMD_M6  = 4'd7,
    CMD_M72 = 4'd8
  } cmd_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_EXEC = 3'd1;
  localparam state_t ST_MOVE = 3'd2;
  localparam state_t ST_TOOL = 3'd3;
  localparam state_t ST_HALT = 3'd4;

  localparam int MS_LINEAR   = 0;
  localparam int MS_INCHES   = 1;
  localparam int MS_ABSOLUTE = 2;
  localparam int MS_RAISE    = 3;
  localparam int MS_TOOL     = 4;

  // Power-up modal set: absolute positioning with the tool raised.
  localparam logic [4:0] MODAL_RESET = 5'b01100;

endpackage

// File: rtl/gcode_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and a flush input that
// empties it in one cycle. DEPTH must be a power of two.
module gcode_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcode_motion_sequencer.sv
// G-code command sequencer: buffers command words, tracks modal state and
// tool position, and issues move / tool-change requests one at a time.
module gcode_motion_sequencer
  import gcode_pkg::*;
#(
  parameter int COORD_W    = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd,
  input  logic [COORD_W-1:0]            x_in,
  input  logic [COORD_W-1:0]            y_in,
  output logic                          mv_valid,
  input  logic                          mv_ready,
  output logic [COORD_W-1:0]            mv_x,
  output logic [COORD_W-1:0]            mv_y,
  output logic                          mv_linear,
  output logic                          tool_req,
  input  logic                          tool_done,
  output logic [4:0]                    modal_state,
  output logic                          err_unknown,
  output logic                          halted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int FW = 4 + 2 * COORD_W;

  state_t             state;
  logic [FW-1:0]      fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      exec_q;
  logic [3:0]         exec_cmd;
  logic [COORD_W-1:0] exec_x;
  logic [COORD_W-1:0] exec_y;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;
  logic [4:0]         modal;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; once raised, valid and its payload hold until then.
  assign cmd_ready   = !fifo_full && (state != ST_HALT);
  assign tool_req    = (state == ST_TOOL);
  assign halted      = (state == ST_HALT);
  assign mv_x        = tgt_x;
  assign mv_y        = tgt_y;
  assign modal_state = modal;
  assign state_dbg   = state;
  assign exec_cmd    = exec_q[FW-1 -: 4];
  assign exec_x      = exec_q[2*COORD_W-1 -: COORD_W];
  assign exec_y      = exec_q[COORD_W-1:0];

  gcode_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (state == ST_HALT),
    .push    (cmd_valid && cmd_ready),
    .wr_data ({cmd, x_in, y_in}),
    .pop     ((state == ST_IDLE) && !fifo_empty),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Unsigned position plus signed offset, clamped to the coordinate range.
  function automatic logic [COORD_W-1:0] rel_target(
    input logic [COORD_W-1:0] p,
    input logic [COORD_W-1:0] off
  );
    logic [COORD_W+1:0] sum;
    sum = {2'b00, p} + {{2{off[COORD_W-1]}}, off};
    if (sum[COORD_W+1])    rel_target = '0;
    else if (sum[COORD_W]) rel_target = '1;
    else                   rel_target = sum[COORD_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      exec_q      <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      tgt_x       <= '0;
      tgt_y       <= '0;
      modal       <= MODAL_RESET;
      mv_valid    <= 1'b0;
      mv_linear   <= 1'b0;
      err_unknown <= 1'b0;
    end else begin
      err_unknown <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            exec_q <= fifo_rd;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          case (exec_cmd)
            CMD_G00, CMD_G01: begin
              modal[MS_LINEAR] <= 1'b1;
              modal[MS_RAISE]  <= 1'b0;
              modal[MS_TOOL]   <= 1'b0;
              mv_linear        <= (exec_cmd == CMD_G01);
              tgt_x <= modal[MS_ABSOLUTE] ? exec_x : rel_target(pos_x, exec_x);
              tgt_y <= modal[MS_ABSOLUTE] ? exec_y : rel_target(pos_y, exec_y);
              state <= ST_MOVE;
            end
            CMD_G20: modal[MS_INCHES]   <= 1'b1;
            CMD_G21: modal[MS_INCHES]   <= 1'b0;
            CMD_G90: modal[MS_ABSOLUTE] <= 1'b1;
            CMD_G91: modal[MS_ABSOLUTE] <= 1'b0;
            CMD_M72: modal[MS_RAISE]    <= 1'b1;
            CMD_M6: begin
              modal[MS_TOOL]   <= 1'b1;
              modal[MS_LINEAR] <= 1'b0;
              state            <= ST_TOOL;
            end
            CMD_M2:  state <= ST_HALT;
            default: err_unknown <= 1'b1;
          endcase
        end
        // First MOVE cycle registers the request; it is offered from the next.
        ST_MOVE: begin
          if (mv_valid && mv_ready) begin
            pos_x    <= tgt_x;
            pos_y    <= tgt_y;
            mv_valid <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            mv_valid <= 1'b1;
          end
        end
        ST_TOOL: begin
          if (tool_done) begin
            modal[MS_TOOL] <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcode_motion_sequencer.sv
// Directed bench for gcode_motion_sequencer with hand-computed expectations.
module tb_gcode_motion_sequencer;
  import gcode_pkg::*;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         mv_valid;
  logic         mv_ready;
  logic [W-1:0] mv_x;
  logic [W-1:0] mv_y;
  logic         mv_linear;
  logic         tool_req;
  logic         tool_done;
  logic [4:0]   modal_state;
  logic         err_unknown;
  logic         halted;
  logic [2:0]   fifo_count;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  gcode_motion_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .x_in        (x_in),
    .y_in        (y_in),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_x        (mv_x),
    .mv_y        (mv_y),
    .mv_linear   (mv_linear),
    .tool_req    (tool_req),
    .tool_done   (tool_done),
    .modal_state (modal_state),
    .err_unknown (err_unknown),
    .halted      (halted),
    .fifo_count  (fifo_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic push(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd = c;
    x_in = x;
    y_in = y;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("push_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(state_dbg == ST_IDLE && fifo_count == 0) && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, (state_dbg == ST_IDLE && fifo_count == 0), 1);
  endtask

  task automatic expect_move(input string tag, input logic [W-1:0] ex,
                             input logic [W-1:0] ey, input logic el);
    int n;
    n = 0;
    while (!mv_valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, mv_valid, 1);
    check({tag, "_x"}, mv_x, ex);
    check({tag, "_y"}, mv_y, ey);
    check({tag, "_lin"}, mv_linear, el);
    if (mv_ready) tick();
  endtask

  // scoreboard: every offered move must match the head of exp_q
  task automatic collect(input int want);
    int got_n;
    int budget;
    got_n = 0;
    budget = 0;
    while (got_n < want && budget < 300) begin
      if (mv_valid) begin
        check("fifo_order", {mv_x, mv_y}, exp_q.pop_front());
        got_n++;
      end
      tick();
      budget++;
    end
    check("moves_seen", got_n, want);
  endtask

  initial begin
    int pulses;
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    x_in = '0;
    y_in = '0;
    mv_ready = 1'b0;
    tool_done = 1'b0;
    do_reset();

    check("rst_modal", modal_state, 5'b01100);
    check("rst_count", fifo_count, 0);
    check("rst_mv_valid", mv_valid, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_halted", halted, 0);
    check("rst_tool_req", tool_req, 0);
    check("rst_err", err_unknown, 0);
    check("rst_state", state_dbg, ST_IDLE);

    // first move latency: valid appears after edge n+3
    mv_ready = 1'b1;
    push(CMD_G01, 14'd100, 14'd200);
    check("lat_n", mv_valid, 0);
    check("lat_count", fifo_count, 1);
    tick();
    check("lat_n1", mv_valid, 0);
    tick();
    check("lat_n2", mv_valid, 0);
    tick();
    check("lat_n3", mv_valid, 1);
    check("g01_x", mv_x, 100);
    check("g01_y", mv_y, 200);
    check("g01_lin", mv_linear, 1);
    tick();
    check("g01_done", mv_valid, 0);
    check("g01_modal", modal_state, 5'b00101);

    // relative mode and saturation
    push(CMD_G00, 14'd30, 14'd40);
    expect_move("abs30", 14'd30, 14'd40, 1'b0);
    push(CMD_G91, 14'd0, 14'd0);
    push(CMD_G00, 14'd16334, 14'd10);
    expect_move("rel_low", 14'd0, 14'd50, 1'b0);
    wait_idle("rel_low");
    check("g91_modal", modal_state, 5'b00001);
    push(CMD_G01, 14'd0, 14'd0);
    expect_move("rel_zero", 14'd0, 14'd50, 1'b1);
    push(CMD_G90, 14'd0, 14'd0);
    push(CMD_G00, 14'd16000, 14'd100);
    expect_move("abs16000", 14'd16000, 14'd100, 1'b0);
    push(CMD_G91, 14'd0, 14'd0);
    push(CMD_G01, 14'd1000, 14'd16284);
    expect_move("rel_high", 14'd16383, 14'd0, 1'b1);
    push(CMD_G90, 14'd0, 14'd0);
    wait_idle("sat");

    // FIFO fill with the controller stalled
    mv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(CMD_G01, 14'(i * 10 + 1), 14'(i * 10 + 2));
      exp_q.push_back({14'(i * 10 + 1), 14'(i * 10 + 2)});
    end
    check("full_count", fifo_count, 4);
    check("full_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd = CMD_G01;
    x_in = 14'd51;
    y_in = 14'd52;
    exp_q.push_back({14'd51, 14'd52});
    tick();
    tick();
    tick();
    check("full_hold", fifo_count, 4);
    fork
      push(CMD_G01, 14'd51, 14'd52);
      begin
        mv_ready = 1'b1;
        collect(6);
      end
    join
    wait_idle("fill");
    check("fill_modal", modal_state, 5'b00101);

    // tool change; stray tool_done is ignored
    tool_done = 1'b1;
    tick();
    tool_done = 1'b0;
    check("stray_done_state", state_dbg, ST_IDLE);
    check("stray_done_modal", modal_state, 5'b00101);
    push(CMD_M6, 14'd0, 14'd0);
    n = 0;
    while (!tool_req && n < 20) begin
      tick();
      n++;
    end
    check("m6_req", tool_req, 1);
    check("m6_modal", modal_state, 5'b10100);
    repeat (10) tick();
    check("m6_hold", tool_req, 1);
    tool_done = 1'b1;
    tick();
    tool_done = 1'b0;
    check("m6_release", tool_req, 0);
    check("m6_end_modal", modal_state, 5'b00100);
    check("m6_end_state", state_dbg, ST_IDLE);
    push(CMD_G20, 14'd0, 14'd0);
    push(CMD_M72, 14'd0, 14'd0);
    wait_idle("g20m72");
    check("g20m72_modal", modal_state, 5'b01110);

    // undefined code
    push(4'd12, 14'd7, 14'd7);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (err_unknown) pulses++;
      tick();
    end
    check("err_pulses", pulses, 1);
    check("err_modal", modal_state, 5'b01110);

    // halt flushes queued work and refuses input
    push(CMD_M2, 14'd0, 14'd0);
    push(CMD_G00, 14'd1, 14'd1);
    n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    check("m2_halted", halted, 1);
    tick();
    check("m2_ready", cmd_ready, 0);
    check("m2_flush", fifo_count, 0);
    check("m2_state", state_dbg, ST_HALT);
    cmd_valid = 1'b1;
    cmd = CMD_G01;
    repeat (3) tick();
    cmd_valid = 1'b0;
    check("m2_no_push", fifo_count, 0);
    check("m2_no_move", mv_valid, 0);
    check("m2_still", halted, 1);

    do_reset();
    check("rst2_halted", halted, 0);
    check("rst2_ready", cmd_ready, 1);
    check("rst2_modal", modal_state, 5'b01100);

    // reset while a move is pending drops it
    mv_ready = 1'b0;
    push(CMD_G01, 14'd9, 14'd9);
    n = 0;
    while (!mv_valid && n < 20) begin
      tick();
      n++;
    end
    check("mid_valid", mv_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_drop", mv_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    mv_ready = 1'b1;
    push(CMD_G91, 14'd0, 14'd0);
    push(CMD_G00, 14'd5, 14'd7);
    expect_move("post_rst", 14'd5, 14'd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
